// File: rtl/imm8_narrow.sv
// imm8_narrow: narrows 8-bit constants into one or two 5-bit signed immediate fields.
// Optional IMM8_NARROW_STATS_EN adds an 8-bit split-word counter (split_count).
`default_nettype none

module imm8_narrow (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] out_imm,
  output logic       out_last,
  output logic       out_split,
  input  logic       out_ready
`ifdef IMM8_NARROW_STATS_EN
  ,
  output logic [7:0] split_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ONE  = 2'd1,
    HI   = 2'd2,
    LO   = 2'd3
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] hold;
  logic       accept;
  logic       fits;

  assign accept = in_valid && in_ready;
  assign fits   = (in_data[7:5] == {3{in_data[4]}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= 8'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        hold <= in_data;
      end
    end
  end

  // Outputs decode only from registered state, so there is no in->out path.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_imm    = 5'd0;
    out_last   = 1'b0;
    out_split  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = fits ? ONE : HI;
        end
      end
      ONE: begin
        out_valid = 1'b1;
        out_imm   = hold[4:0];
        out_last  = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      HI: begin
        out_valid = 1'b1;
        out_imm   = {1'b0, hold[7:4]};
        out_split = 1'b1;
        if (out_ready) begin
          next_state = LO;
        end
      end
      LO: begin
        out_valid = 1'b1;
        out_imm   = {1'b0, hold[3:0]};
        out_last  = 1'b1;
        out_split = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

`ifdef IMM8_NARROW_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_count <= 8'd0;
    end else if (accept && !fits) begin
      split_count <= split_count + 8'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/imm8_narrow.md
# imm8_narrow

Narrows 8-bit two's-complement constants into the 5-bit signed immediate fields consumed by the datapath's 5→8 sign extender. Words that fit in signed 5 bits (−16..15) are emitted as one field. All other words are split into a two-field high/low sequence that the load-immediate/shift path rebuilds exactly. Sits between the constant source (loader/assembler front end) and the instruction-field packer, with valid/ready handshakes on both sides.

## Interface
Parameters:
- none; widths are fixed at 8-bit input and 5-bit field.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  `in_data` is valid.
- `in_data`  input  8  two's-complement constant.
- `in_ready`  output  1  block can accept a word this cycle.
- `out_valid`  output  1  `out_imm` is valid.
- `out_imm`  output  5  immediate field.
- `out_last`  output  1  current beat is the final beat for this word.
- `out_split`  output  1  current word needed two beats; constant across both beats.
- `out_ready`  input  1  consumer accepts the beat this cycle.
- `split_count`  output  8  present only with `IMM8_NARROW_STATS_EN`.

## Operation
- Fit test: the word fits iff `in_data[7:5] == {3{in_data[4]}}`.
- State machine with states IDLE, ONE, HI, LO.
  - IDLE: `in_ready`=1, `out_valid`=0. On accept, the word is latched into an 8-bit holding register. Next state is ONE if the word fits, otherwise HI.
  - ONE: `out_imm` = `hold[4:0]`, `out_last`=1, `out_split`=0. On `out_ready`, go to IDLE.
  - HI: `out_imm` = {1'b0, `hold[7:4]`}, `out_last`=0, `out_split`=1. On `out_ready`, go to LO.
  - LO: `out_imm` = {1'b0, `hold[3:0]`}, `out_last`=1, `out_split`=1. On `out_ready`, go to IDLE.
- Reconstruction contract for the consumer: result = (sext5(HI) << 4) | LO[3:0], truncated to 8 bits, equals the original word. For ONE, result = sext5(ONE).
- `in_ready` is high only in IDLE. Input is ignored in every other state.
- Outputs hold stable while `out_valid`=1 and `out_ready`=0 (no change of data or flags under backpressure).
- Holding register loads only on accept (`in_valid && in_ready`).

## Timing
- Reset (async assert, sync release): state=IDLE. `in_ready`=1, `out_valid`=0, `out_imm`=0, `out_last`=0, `out_split`=0, `split_count`=0, holding register=0.
- Latency: a word accepted at edge N presents its first beat from cycle N+1 (registered, no combinational in→out path).
- Throughput:
  - Fitting word: one word per 2 cycles (IDLE, ONE).
  - Split word: one word per 3 cycles (IDLE, HI, LO).
  - Backpressure adds stall cycles.
- `out_ready` high while `out_valid`=0 has no effect.
- Reset asserted mid-sequence (in HI or LO) aborts the word. The remaining beat is never emitted, and the output side returns to IDLE immediately.
- `in_valid` may drop while in IDLE without side effects; no data is captured unless accepted.

## Configuration
- `IMM8_NARROW_STATS_EN` defined:
  - Adds the `split_count` output, an 8-bit counter that increments when a word is accepted that will be split (accept in IDLE with the fit test false).
  - Wraps 255→0.
  - Reset to 0.
- Undefined: no counter logic and no `split_count` port. All other behaviour is identical.

## Test plan
- Fit boundary: inputs 0x0F, 0xF0, 0x00, 0xFF.
  - Each produces one beat with `last`=1 and `split`=0.
  - `out_imm` values: 0x0F, 0x10, 0x00, 0x1F respectively.
- Split: input 0x10 → beats 0x01 then 0x00. Input 0x80 → beats 0x08 then 0x00. Input 0xEF → beats 0x0E then 0x0F. `split`=1 on both beats; `last` is 0 then 1.
- Exhaustive round-trip: all 256 inputs with random `out_ready`. The reconstructed value equals the input, and outputs stay stable during every stall.
- Backpressure: input 0x5A with `out_ready` held low for 4 cycles. `out_imm`=0x05 is held for 5 cycles, then 0x0A is emitted. `in_ready` stays 0 until after the LO beat is accepted.
- Reset mid-operation: assert `rst_n`=0 in state LO for input 0x7F. Outputs go to reset values asynchronously. After release, input 0x03 yields a single beat 0x03.
- Stats (macro defined): feed 300 split words. `split_count` = 300 mod 256 = 44. Fitting words never increment it.
